// File: rtl/ov7670_cap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_cap_pkg
// Purpose  : Shared state encoding, parameter defaults and pixel packing
//            helper for the OV7670 RGB444 capture block.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ov7670_cap_pkg;

   localparam int MAX_ADDRESS_DEF = 30720;   // 160x192 frame buffer
   localparam int ADDR_W_DEF      = 15;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_FRAME = 2'd1,
      ST_CAPTURE    = 2'd2
   } cap_state_t;

   // First camera byte carries R in its low nibble, second byte is {G,B}.
   function automatic logic [11:0] rgb444_pack(input logic [3:0] red,
                                                input logic [7:0] green_blue);
      return {red, green_blue};
   endfunction

endpackage
`default_nettype wire

// File: rtl/rgb444_pixel_assembler.sv
`default_nettype none
// ============================================================================
// Module   : rgb444_pixel_assembler
// Purpose  : Pairs camera bytes into 12-bit RGB444 pixels. Tracks the byte
//            phase while HREF is high; an unpaired byte at HREF fall is lost.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            clear         - frame start, forces phase 0
//            active        - high while the capture FSM is in CAPTURE
//            href, data    - registered camera line-valid and byte
//            pix_valid     - high in the cycle the second byte is presented
//            pix           - assembled {R,G,B}, valid with pix_valid
// Revision : 1.0 - initial release
// ============================================================================
module rgb444_pixel_assembler
   import ov7670_cap_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        active,
   input  logic        href,
   input  logic [7:0]  data,
   output logic        pix_valid,
   output logic [11:0] pix
);

   logic       phase;
   logic [3:0] red;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         phase <= 1'b0;
         red   <= 4'd0;
      end else if (active && href) begin
         phase <= ~phase;
         if (!phase) begin
            red <= data[3:0];
         end
      end else begin
         // HREF low (or not capturing) drops any half pixel
         phase <= 1'b0;
      end
   end

   assign pix_valid = active & href & phase;
   assign pix       = rgb444_pack(red, data);

endmodule
`default_nettype wire

// File: rtl/ov7670_capture.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_capture
// Purpose  : Captures RGB444 frames from an OV7670 camera into a BRAM write
//            port. Armed by an ENABLE_I rising edge, starts on VSYNC fall,
//            ends on VSYNC rise with a one-cycle FRAME_DONE_O pulse.
//            Writes beyond MAX_ADDRESS_P pixels in a frame are dropped.
// Ports    : CLK_25_I, RST_I        - PCLK, synchronous active-high reset
//            ENABLE_I               - arm on rising edge
//            CAM_VSYNC_I/HREF_I/DATA_I - camera interface
//            PXL_O, ADDRESS_O, WR_EN_O - BRAM write port
//            FRAME_DONE_O, BUSY_O   - status
// Config   : OV7670_CAPTURE_TEST_PATTERN_EN - when defined, pixel data is
//            replaced by an address-derived pattern.
// Revision : 1.0 - initial release
// ============================================================================
module ov7670_capture
   import ov7670_cap_pkg::*;
#(
   parameter int MAX_ADDRESS_P = MAX_ADDRESS_DEF,
   parameter int ADDR_W_P      = ADDR_W_DEF
)(
   input  logic                CLK_25_I,
   input  logic                RST_I,
   input  logic                ENABLE_I,
   input  logic                CAM_VSYNC_I,
   input  logic                CAM_HREF_I,
   input  logic [7:0]          CAM_DATA_I,
   output logic [11:0]         PXL_O,
   output logic [ADDR_W_P-1:0] ADDRESS_O,
   output logic                WR_EN_O,
   output logic                FRAME_DONE_O,
   output logic                BUSY_O
);

   // One extra bit so the count can reach MAX_ADDRESS_P without wrapping.
   localparam logic [ADDR_W_P:0] MAX_CNT = (ADDR_W_P+1)'(MAX_ADDRESS_P);

   logic         vsync_r, href_r, enable_r;
   logic [7:0]   data_r;
   logic         vsync_d, enable_d;
   logic [1:0]   warm;
   logic         enable_rise, vsync_fall, vsync_rise;

   cap_state_t   state, state_nxt;
   logic         frame_start, frame_done_nxt;

   logic [ADDR_W_P:0] count;
   logic         pix_valid, write;
   logic [11:0]  asm_pix, pix_data;

   // Input registers plus one history stage for edge detection.
   always_ff @(posedge CLK_25_I) begin
      if (RST_I) begin
         vsync_r  <= 1'b0;
         href_r   <= 1'b0;
         enable_r <= 1'b0;
         data_r   <= 8'd0;
         vsync_d  <= 1'b0;
         enable_d <= 1'b0;
         warm     <= 2'b00;
      end else begin
         vsync_r  <= CAM_VSYNC_I;
         href_r   <= CAM_HREF_I;
         enable_r <= ENABLE_I;
         data_r   <= CAM_DATA_I;
         vsync_d  <= vsync_r;
         enable_d <= enable_r;
         warm     <= {warm[0], 1'b1};
      end
   end

   // enable_d only holds a real post-reset sample once warm[1] is set, so an
   // ENABLE_I level held through reset never looks like a rising edge.
   assign enable_rise = enable_r & ~enable_d & warm[1];
   assign vsync_fall  = vsync_d & ~vsync_r;
   assign vsync_rise  = vsync_r & ~vsync_d;

   always_ff @(posedge CLK_25_I) begin
      if (RST_I) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      frame_start    = 1'b0;
      frame_done_nxt = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable_rise) state_nxt = ST_WAIT_FRAME;
         end
         ST_WAIT_FRAME: begin
            if (vsync_fall) begin
               state_nxt   = ST_CAPTURE;
               frame_start = 1'b1;
            end
         end
         ST_CAPTURE: begin
            if (vsync_rise) begin
               frame_done_nxt = 1'b1;
               state_nxt      = enable_r ? ST_WAIT_FRAME : ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   rgb444_pixel_assembler u_asm (
      .clk       (CLK_25_I),
      .rst       (RST_I),
      .clear     (frame_start),
      .active    (state == ST_CAPTURE),
      .href      (href_r),
      .data      (data_r),
      .pix_valid (pix_valid),
      .pix       (asm_pix)
   );

`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
   assign pix_data = {count[3:0], count[7:4], count[11:8]};
`else
   assign pix_data = asm_pix;
`endif

   assign write = pix_valid && (count < MAX_CNT);

   always_ff @(posedge CLK_25_I) begin
      if (RST_I) begin
         count        <= '0;
         PXL_O        <= 12'd0;
         ADDRESS_O    <= '0;
         WR_EN_O      <= 1'b0;
         FRAME_DONE_O <= 1'b0;
      end else begin
         WR_EN_O      <= 1'b0;
         FRAME_DONE_O <= frame_done_nxt;
         if (frame_start) begin
            count <= '0;
         end else if (write) begin
            count     <= count + 1'b1;
            WR_EN_O   <= 1'b1;
            ADDRESS_O <= count[ADDR_W_P-1:0];
            PXL_O     <= pix_data;
         end
      end
   end

   assign BUSY_O = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ov7670_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_ov7670_capture
// Purpose  : Self-checking bench for ov7670_capture. Camera bytes are
//            randomised; expected BRAM writes come from a byte-pair model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ov7670_capture;

   localparam int MAX_PIX = 30720;
   localparam int AW      = 15;

   logic          clk = 1'b0;
   logic          rst, enable, vsync, href;
   logic [7:0]    data;
   logic [11:0]   pxl;
   logic [AW-1:0] addr;
   logic          wr_en, frame_done, busy;

   int            n_checks = 0;
   int            n_err    = 0;
   int            pcyc     = 0;
   int            fd_cnt   = 0;
   int            wr_idle  = 0;
   int            drive_cyc;

   logic [AW-1:0] wa_q[$];
   logic [11:0]   wd_q[$];
   int            wc_q[$];
   logic [11:0]   exp_q[$];
   logic [7:0]    line_q[$];

   always #20 clk = ~clk;

   ov7670_capture #(.MAX_ADDRESS_P(MAX_PIX), .ADDR_W_P(AW)) dut (
      .CLK_25_I     (clk),
      .RST_I        (rst),
      .ENABLE_I     (enable),
      .CAM_VSYNC_I  (vsync),
      .CAM_HREF_I   (href),
      .CAM_DATA_I   (data),
      .PXL_O        (pxl),
      .ADDRESS_O    (addr),
      .WR_EN_O      (wr_en),
      .FRAME_DONE_O (frame_done),
      .BUSY_O       (busy)
   );

   always @(posedge clk) pcyc <= pcyc + 1;

   // Write/pulse recorder, sampled mid-cycle
   always @(negedge clk) begin
      if (wr_en) begin
         wa_q.push_back(addr);
         wd_q.push_back(pxl);
         wc_q.push_back(pcyc);
         if (!busy) wr_idle++;
      end
      if (frame_done) fd_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_line();
      foreach (line_q[i]) begin
         @(negedge clk);
         href      = 1'b1;
         data      = line_q[i];
         drive_cyc = pcyc;
      end
      @(negedge clk);
      href = 1'b0;
      data = 8'd0;
   endtask

   // Reference: bytes pair up from the start of each line, {b0[3:0], b1};
   // an unpaired last byte is ignored; at most MAX_PIX pixels per frame.
   task automatic model_line();
      for (int i = 0; i + 1 < line_q.size(); i += 2) begin
         if (exp_q.size() < MAX_PIX) exp_q.push_back({line_q[i][3:0], line_q[i+1]});
      end
   endtask

   task automatic rand_line(input int nbytes);
      line_q.delete();
      for (int i = 0; i < nbytes; i++) line_q.push_back(8'($urandom));
   endtask

   task automatic frame_begin();
      @(negedge clk);
      vsync = 1'b0;
      tick(3);
   endtask

   task automatic frame_end();
      tick(3);
      vsync = 1'b1;
      tick(4);
   endtask

   task automatic check_writes(input string tag);
      check({tag, "_count"}, wa_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < wa_q.size(); i++) begin
         check({tag, "_addr"}, 32'(wa_q[i]), i);
         check({tag, "_data"}, 32'(wd_q[i]), 32'(exp_q[i]));
      end
      wa_q.delete(); wd_q.delete(); wc_q.delete(); exp_q.delete();
   endtask

   initial begin
      #(40 * 90000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int fd0, rst_cyc, late;
      rst = 1'b1; enable = 1'b1; vsync = 1'b1; href = 1'b0; data = 8'd0;
      tick(3);
      check("rst_pxl",  32'(pxl), 0);
      check("rst_addr", 32'(addr), 0);
      check("rst_wr",   32'(wr_en), 0);
      check("rst_fd",   32'(frame_done), 0);
      check("rst_busy", 32'(busy), 0);

      // Enable held high out of reset must not arm
      rst = 1'b0;
      tick(6);
      check("hold_no_arm", 32'(busy), 0);
      enable = 1'b0; tick(3);
      enable = 1'b1; tick(3);
      check("arm_busy", 32'(busy), 1);

      // Directed line: 0x0A,0xBC,0x03,0x45
      frame_begin();
      line_q = '{8'h0A, 8'hBC, 8'h03, 8'h45};
      model_line();
      send_line();
      tick(4);
      if (wc_q.size() >= 2) check("latency", wc_q[1], drive_cyc + 2);
      else                  check("latency_present", wc_q.size(), 2);
      check_writes("dir4");
      frame_end();
      check("dir4_fd", fd_cnt, 1);
      check("rearm_wait", 32'(busy), 1);

      // Odd line: third byte dropped, next line starts on phase 0
      frame_begin();
      line_q = '{8'h01, 8'h23, 8'h0F}; model_line(); send_line(); tick(2);
      line_q = '{8'h04, 8'h56};        model_line(); send_line();
      frame_end();
      check("odd_n", exp_q.size(), 2);
      check_writes("odd");
      check("odd_fd", fd_cnt, 2);

      // Randomised frames
      for (int f = 0; f < 3; f++) begin
         frame_begin();
         for (int l = 0; l < int'($urandom_range(5, 2)); l++) begin
            rand_line(int'($urandom_range(16, 1)));
            model_line();
            send_line();
            tick(int'($urandom_range(3, 1)));
         end
         frame_end();
         check_writes("rnd");
         check("rnd_fd", fd_cnt, 3 + f);
      end

      // Overflow: 30725 pixels in one frame, only 30720 written
      fd0 = fd_cnt;
      frame_begin();
      rand_line(2 * 30725);
      model_line();
      send_line();
      frame_end();
      check("ovf_count", wa_q.size(), 30720);
      if (wa_q.size() > 0) check("ovf_last_addr", 32'(wa_q[wa_q.size()-1]), 30719);
      check_writes("ovf");
      check("ovf_fd", fd_cnt, fd0 + 1);

      // Enable dropped mid-frame: frame completes, then idle
      fd0 = fd_cnt;
      frame_begin();
      rand_line(8); model_line(); send_line(); tick(2);
      enable = 1'b0;
      rand_line(8); model_line(); send_line();
      frame_end();
      check_writes("endrop");
      check("endrop_fd", fd_cnt, fd0 + 1);
      check("endrop_idle", 32'(busy), 0);
      frame_begin();
      rand_line(4); send_line();
      frame_end();
      check("idle_nowr", wa_q.size(), 0);
      check("idle_nofd", fd_cnt, fd0 + 1);

      // Reset mid-line with enable held high
      enable = 1'b1; tick(3);
      check("rearm2", 32'(busy), 1);
      fd0 = fd_cnt;
      frame_begin();
      wa_q.delete(); wd_q.delete(); wc_q.delete();
      rst_cyc = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         href = 1'b1;
         data = 8'($urandom);
         if (i == 5) begin rst = 1'b1; rst_cyc = pcyc; end
         else rst = 1'b0;
      end
      @(negedge clk); href = 1'b0; rst = 1'b0;
      frame_end();
      late = 0;
      foreach (wc_q[i]) if (wc_q[i] > rst_cyc) late++;
      check("rst_no_late_wr", late, 0);
      check("rst_no_fd", fd_cnt, fd0);
      check("rst_idle", 32'(busy), 0);
      check("rst_out_pxl", 32'(pxl), 0);
      check("rst_out_addr", 32'(addr), 0);
      check("rst_out_wr", 32'(wr_en), 0);
      check("rst_out_fd", 32'(frame_done), 0);
      wa_q.delete(); wd_q.delete(); wc_q.delete();
      frame_begin();
      rand_line(6); send_line();
      frame_end();
      check("rst_no_rearm_wr", wa_q.size(), 0);
      check("rst_no_rearm_busy", 32'(busy), 0);
      check("never_wr_idle", wr_idle, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
